// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// default operand widths.
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  localparam int DVD_W_DEF = 8;
  localparam int DVR_W_DEF = 4;

endpackage

// File: rtl/divider_datapath.sv
// Arithmetic half of seq_divider: operand, partial-remainder and quotient
// working registers, trial subtractor, restore mux and held result registers.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVR_W = DVR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             commit,
  input  logic             latch,
  input  logic             latch_z,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVR_W-1:0] divisor,
  output logic             borrow,
  output logic             dvr_zero,
  output logic [DVD_W-1:0] quotient,
  output logic [DVR_W-1:0] remainder,
  output logic             dbz
);

  logic [DVD_W-1:0] dvd_r, quo_w, quo_nxt;
  logic [DVR_W-1:0] dvr_r;
  logic [DVR_W:0]   prem, prem_nxt;
  logic [DVR_W+1:0] shifted, diff;

  // Top bit of shifted is always 0 (prem < divisor), but keeping it in the
  // subtraction makes the borrow fall out of the MSB directly.
  assign shifted  = {prem, dvd_r[DVD_W-1]};
  assign diff     = shifted - {2'b00, dvr_r};
  assign borrow   = diff[DVR_W+1];
  assign prem_nxt = commit ? diff[DVR_W:0] : shifted[DVR_W:0];
  assign quo_nxt  = {quo_w[DVD_W-2:0], commit};
  assign dvr_zero = (divisor == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r <= '0;
      dvr_r <= '0;
      prem  <= '0;
      quo_w <= '0;
    end else if (load) begin
      dvd_r <= dividend;
      dvr_r <= divisor;
      prem  <= '0;
      quo_w <= '0;
    end else if (step) begin
      dvd_r <= {dvd_r[DVD_W-2:0], 1'b0};
      prem  <= prem_nxt;
      quo_w <= quo_nxt;
    end
  end

  // Results take the post-step values so the final step and the latch share an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (latch_z) begin
      quotient  <= '1;
      remainder <= dividend[DVR_W-1:0];
      dbz       <= 1'b1;
    end else if (latch) begin
      quotient  <= quo_nxt;
      remainder <= prem_nxt[DVR_W-1:0];
      dbz       <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock. Holds the FSM and
// step counter; arithmetic lives in divider_datapath.
module seq_divider
  import divider_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVR_W = DVR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVR_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVR_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          load, step, latch, latch_z, commit, borrow, dvr_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      if (load)      cnt <= CW'(DVD_W - 1);
      else if (step) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    latch     = 1'b0;
    latch_z   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load = 1'b1;
        if (dvr_zero) begin
          latch_z   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt == '0) begin
          latch     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign commit = step & ~borrow;

  divider_datapath #(.DVD_W(DVD_W), .DVR_W(DVR_W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .commit   (commit),
    .latch    (latch),
    .latch_z  (latch_z),
    .dividend (dividend),
    .divisor  (divisor),
    .borrow   (borrow),
    .dvr_zero (dvr_zero),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios, random operations
// and a full operand sweep against an arithmetic reference model.
module tb_seq_divider;

  localparam int DVD_W = 8;
  localparam int DVR_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DVD_W-1:0] dividend = '0;
  logic [DVR_W-1:0] divisor = '0;
  logic [DVD_W-1:0] quotient;
  logic [DVR_W-1:0] remainder;
  logic             busy, done, dbz;

  int n_chk = 0;
  int n_err = 0;
  int prev_q = 0, prev_r = 0, prev_z = 0;

  always #5 clk = ~clk;

  seq_divider #(.DVD_W(DVD_W), .DVR_W(DVR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << DVD_W) - 1;
      r = a % (1 << DVR_W);
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Called at a negedge in IDLE. lat counts edges after the accepting edge.
  // poke: cycle at which a stray start (50/5) is driven; rst_at: abort cycle.
  task automatic do_op(input int a, input int b, input int poke, input int rst_at);
    int q, r, z, lat, pulses;
    ref_div(a, b, q, r, z);
    start = 1'b1; dividend = DVD_W'(a); divisor = DVR_W'(b);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    chk("busy_after_start", busy, 1);
    while (!done && lat < 20) begin
      if (lat == rst_at) begin
        rst = 1'b0;
        #1;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (done) pulses++;
        end
        chk("no_done_after_abort", pulses, 0);
        prev_q = 0; prev_r = 0; prev_z = 0;
        return;
      end
      if (lat == 3) begin
        chk("hold_quotient", quotient, prev_q);
        chk("hold_remainder", remainder, prev_r);
        chk("hold_dbz", dbz, prev_z);
      end
      if (lat == poke) begin
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk($sformatf("latency %0d/%0d", a, b), lat, (b == 0) ? 0 : DVD_W);
    chk($sformatf("quotient %0d/%0d", a, b), quotient, q);
    chk($sformatf("remainder %0d/%0d", a, b), remainder, r);
    chk($sformatf("dbz %0d/%0d", a, b), dbz, z);
    prev_q = q; prev_r = r; prev_z = z;
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("busy_idle_gap", busy, 0);
    chk("result_held_idle", quotient, q);
  endtask

  initial begin
    #12;
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_op(100, 7, -1, -1);
    do_op(255, 15, -1, -1);
    do_op(5, 9, -1, -1);
    do_op(200, 0, -1, -1);
    do_op(100, 7, 3, -1);
    do_op(100, 7, -1, 4);
    do_op(9, 3, -1, -1);
    do_op(0, 1, -1, -1);
    do_op(255, 1, -1, -1);

    for (int i = 0; i < 150; i++)
      do_op(int'($urandom_range(255)), int'($urandom_range(15)), -1, -1);

    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        do_op(a, b, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
